// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl
//   Drains a 4-port output buffer row by row onto a valid/ready stream.
//   Each beat carries four consecutive rows (one per read port) across all
//   WIDTH lanes. m_keep marks which rows are real, and m_last tags the final beat.
//
// Ports
//   clk, nrst          : clock, asynchronous active-low reset
//   start              : one-cycle drain request (honoured in IDLE only)
//   base_addr          : first row address, sampled with start
//   num_rows           : rows to drain (0..32), sampled with start
//   busy, done         : drain in progress / one-cycle completion pulse
//   add_1..add_4       : read addresses broadcast to every lane
//   out1..out4         : buffer read data, combinationally valid with add_k
//   m_valid, m_ready   : stream handshake
//   m_data[k][lane]    : row k of the beat (row k comes from port k+1)
//   m_keep, m_last     : valid rows of the beat / final beat marker

// Per-lane beat register: captures one entry from each read port on load.
module obuf_drain_lane #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] d1,
   input  logic [DATA_WIDTH-1:0] d2,
   input  logic [DATA_WIDTH-1:0] d3,
   input  logic [DATA_WIDTH-1:0] d4,
   output logic [DATA_WIDTH-1:0] q0,
   output logic [DATA_WIDTH-1:0] q1,
   output logic [DATA_WIDTH-1:0] q2,
   output logic [DATA_WIDTH-1:0] q3
);
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         q0 <= '0;
         q1 <= '0;
         q2 <= '0;
         q3 <= '0;
      end else if (load) begin
         q0 <= d1;
         q1 <= d2;
         q2 <= d3;
         q3 <= d4;
      end
   end
endmodule

module obuf_drain_ctrl #(
   parameter int WIDTH      = 32,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [4:0]            base_addr,
   input  logic [5:0]            num_rows,
   output logic                  busy,
   output logic                  done,
   output logic [4:0]            add_1,
   output logic [4:0]            add_2,
   output logic [4:0]            add_3,
   output logic [4:0]            add_4,
   input  logic [DATA_WIDTH-1:0] out1 [WIDTH-1:0],
   input  logic [DATA_WIDTH-1:0] out2 [WIDTH-1:0],
   input  logic [DATA_WIDTH-1:0] out3 [WIDTH-1:0],
   input  logic [DATA_WIDTH-1:0] out4 [WIDTH-1:0],
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data [3:0][WIDTH-1:0],
   output logic [3:0]            m_keep,
   output logic                  m_last
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [4:0]      ptr;
   logic [5:0]      rem;
   logic [3:0][4:0] run_add;   // addresses driven while in RUN
   logic [3:0][4:0] add_q;     // last RUN addresses, held in IDLE/FLUSH
   logic            load, hs, last_load;
   logic [3:0]      keep_nxt;
   logic [5:0]      take;

   // 5-bit arithmetic gives the 31 -> 0 wrap for free
   always_comb begin
      for (int k = 0; k < 4; k++) run_add[k] = ptr + 5'(k);
   end

   assign add_1 = (state == RUN) ? run_add[0] : add_q[0];
   assign add_2 = (state == RUN) ? run_add[1] : add_q[1];
   assign add_3 = (state == RUN) ? run_add[2] : add_q[2];
   assign add_4 = (state == RUN) ? run_add[3] : add_q[3];

   assign hs        = m_valid & m_ready;
   // A handshake in the same cycle frees the register, so the beats are back to back
   assign load      = (state == RUN) && (rem != 6'd0) && (!m_valid || m_ready);
   assign last_load = (rem <= 6'd4);
   assign take      = last_load ? rem : 6'd4;
   assign keep_nxt  = (rem >= 6'd4) ? 4'hf : 4'((4'd1 << rem[1:0]) - 4'd1);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && num_rows != 6'd0) state_nxt = RUN;
         RUN:     if (load && last_load)         state_nxt = FLUSH;
         FLUSH:   if (hs && m_last)              state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr     <= '0;
         rem     <= '0;
         add_q   <= '0;
         m_valid <= 1'b0;
         m_keep  <= '0;
         m_last  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            if (num_rows == 6'd0) begin
               done <= 1'b1;             // empty drain: no beat, just complete
            end else begin
               ptr <= base_addr;
               rem <= num_rows;
            end
         end
         if (state == RUN) add_q <= run_add;
         if (load) begin
            m_valid <= 1'b1;
            m_keep  <= keep_nxt;
            m_last  <= last_load;
            ptr     <= ptr + 5'd4;
            rem     <= rem - take;
         end else if (hs) begin
            m_valid <= 1'b0;
         end
         if (state == FLUSH && hs && m_last) done <= 1'b1;
      end
   end

   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      obuf_drain_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clk  (clk),
         .nrst (nrst),
         .load (load),
         .d1   (out1[l]),
         .d2   (out2[l]),
         .d3   (out3[l]),
         .d4   (out4[l]),
         .q0   (m_data[0][l]),
         .q1   (m_data[1][l]),
         .q2   (m_data[2][l]),
         .q3   (m_data[3][l])
      );
   end
endmodule
